// File: rtl/uart_rx_datapath.sv
// ---------------------------------------------------------------------------
// uart_rx_datapath
//
// UART 8N1 receive path. The asynchronous serial line passes through a
// two-flop synchroniser. A start bit is qualified at its middle, then each
// data bit and the stop bit are sampled at mid-bit. A good frame produces a
// one-cycle rx_valid strobe with the byte on rx_data. A low stop bit produces
// a one-cycle rx_frame_err strobe and parks the receiver in BREAK until the
// line returns high, so a held-low line raises only one error.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   uart_rx_in    raw serial line, idle high, asynchronous to clk
//   rx_data       last correctly received byte (LSB first on the wire)
//   rx_valid      one-cycle strobe, rx_data is new this cycle
//   rx_frame_err  one-cycle strobe, stop bit was sampled low
//   rx_busy       high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_datapath #(
  parameter int CLKS_PER_BIT = 868,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam int HALF = CLKS_PER_BIT / 2;

  // Counter values at which the line is sampled.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync_1;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Synchroniser. Both stages come out of reset at 1 so a reset does not
  // look like a falling edge on an idle line.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours; blocking here would
  // collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= uart_rx_in;
      rx_s   <= sync_1;
    end
  end

  // Receive FSM with registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      // NOTE: the shift register is an ordinary bank of flops, not a RAM,
      // so it takes a reset like the rest of the state.
      shift        <= '0;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle and are raised only on the
      // cycle an event is decided, which guarantees single-cycle pulses.
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end

        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A line that is already high again at mid-start was a glitch.
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            // LSB arrives first, so shift right and insert at the MSB.
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data  <= shift;
              rx_valid <= 1'b1;
              // Straight to IDLE at mid-stop so a back-to-back start bit is
              // caught at its falling edge.
              state    <= S_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_datapath.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_datapath
//
// Three receiver instances (16, 4 and 17 clocks per bit) share clock and
// reset; one at a time is selected and driven, the others see an idle line.
// Expected frames are queued when driven and checked as the selected
// receiver strobes.
// ---------------------------------------------------------------------------
module tb_uart_rx_datapath;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic line;
  int   sel;

  logic       line_16, line_4, line_17;
  logic [7:0] data_16, data_4, data_17;
  logic       valid_16, valid_4, valid_17;
  logic       err_16, err_4, err_17;
  logic       busy_16, busy_4, busy_17;

  logic [7:0] act_data;
  logic       act_valid, act_err, act_busy;

  exp_t       sb[$];
  int         vtimes[$];
  logic [7:0] model_last;
  int         cyc;
  int         t_fall;
  int         n_tests;
  int         n_fail;
  logic       prev_busy;
  logic       prev_strobe;

  uart_rx_datapath #(.CLKS_PER_BIT(16), .CNT_W(16)) u_dut_16 (
    .clk(clk), .rst_n(rst_n), .uart_rx_in(line_16),
    .rx_data(data_16), .rx_valid(valid_16), .rx_frame_err(err_16), .rx_busy(busy_16)
  );

  uart_rx_datapath #(.CLKS_PER_BIT(4), .CNT_W(8)) u_dut_4 (
    .clk(clk), .rst_n(rst_n), .uart_rx_in(line_4),
    .rx_data(data_4), .rx_valid(valid_4), .rx_frame_err(err_4), .rx_busy(busy_4)
  );

  uart_rx_datapath #(.CLKS_PER_BIT(17), .CNT_W(8)) u_dut_17 (
    .clk(clk), .rst_n(rst_n), .uart_rx_in(line_17),
    .rx_data(data_17), .rx_valid(valid_17), .rx_frame_err(err_17), .rx_busy(busy_17)
  );

  assign line_16 = (sel == 0) ? line : 1'b1;
  assign line_4  = (sel == 1) ? line : 1'b1;
  assign line_17 = (sel == 2) ? line : 1'b1;

  always_comb begin
    act_data  = data_16;
    act_valid = valid_16;
    act_err   = err_16;
    act_busy  = busy_16;
    case (sel)
      1: begin
        act_data = data_4;  act_valid = valid_4;  act_err = err_4;  act_busy = busy_4;
      end
      2: begin
        act_data = data_17; act_valid = valid_17; act_err = err_17; act_busy = busy_17;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cpb_of(input int s);
    return (s == 1) ? 4 : (s == 2) ? 17 : 16;
  endfunction

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      line = v;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    int cpb;
    cpb = cpb_of(sel);
    @(negedge clk);
    line   = 1'b0;
    t_fall = cyc;
    hold(1'b0, cpb - 1);
    for (int i = 0; i < 8; i++) hold(b[i], cpb);
    hold(stop_bit, cpb);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    sb.push_back(e);
    send_byte(b, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    prev_busy   = 1'b0;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (act_valid || act_err) begin
        check("excl", {31'd0, act_valid & act_err}, 0);
        check("one_cycle", {31'd0, prev_strobe}, 0);
        check("busy_before", {31'd0, prev_busy}, 1);
        // Busy drops with rx_valid; it stays high into BREAK on an error.
        check("busy_at_strobe", {31'd0, act_busy}, {31'd0, act_err});
        check("sb_nonempty", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("kind", {31'd0, act_err}, {31'd0, e.is_err});
          if (!e.is_err) begin
            check("data", {24'd0, act_data}, {24'd0, e.data});
            model_last = e.data;
            vtimes.push_back(cyc);
          end else begin
            check("data_hold", {24'd0, act_data}, {24'd0, model_last});
          end
        end
      end
      prev_busy   = act_busy;
      prev_strobe = act_valid | act_err;
    end
  end

  initial begin
    exp_t e;
    int   lat;
    int   gap;
    n_tests    = 0;
    n_fail     = 0;
    sel        = 0;
    line       = 1'b1;
    model_last = 8'h00;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", {24'd0, act_data}, 0);
    check("rst_valid", {31'd0, act_valid}, 0);
    check("rst_err", {31'd0, act_err}, 0);
    check("rst_busy", {31'd0, act_busy}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Short low glitch: rejected at mid-start.
    hold(1'b0, 4);
    hold(1'b1, 40);
    check("glitch_busy", {31'd0, act_busy}, 0);
    check("glitch_data", {24'd0, act_data}, 8'h00);

    // Single ideal frame, with latency measured from the falling edge.
    vtimes.delete();
    send_good(8'hA5);
    wait_drain(200);
    lat = (vtimes.size() != 0) ? vtimes[$] - t_fall : -1;
    check($sformatf("latency_%0d", lat), {31'd0, lat >= 154 && lat <= 156}, 1);
    hold(1'b1, 20);

    // Framing error, line held low, then release and a good frame.
    e.is_err = 1'b1;
    e.data   = 8'h00;
    sb.push_back(e);
    send_byte(8'h3C, 1'b0);
    hold(1'b0, 40);
    check("break_busy", {31'd0, act_busy}, 1);
    check("break_data", {24'd0, act_data}, 8'hA5);
    hold(1'b1, 8);
    check("break_exit", {31'd0, act_busy}, 0);
    hold(1'b1, 12);
    send_good(8'h81);
    wait_drain(200);
    hold(1'b1, 20);

    // Back-to-back frames with no idle gap.
    vtimes.delete();
    send_good(8'h00);
    send_good(8'hFF);
    send_good(8'h55);
    wait_drain(200);
    check("b2b_count", vtimes.size(), 3);
    for (int i = 1; i < vtimes.size(); i++) begin
      gap = vtimes[i] - vtimes[i-1];
      check($sformatf("b2b_gap_%0d", gap), {31'd0, gap >= 159 && gap <= 161}, 1);
    end
    hold(1'b1, 20);

    // Reset in the middle of data bit 4 of 8'hC3: no strobe may follow.
    @(negedge clk);
    line = 1'b0;
    hold(1'b0, 15);
    for (int i = 0; i < 4; i++) hold(((8'hC3 >> i) & 8'h01) != 0, 16);
    hold(1'b0, 8);
    rst_n = 1'b0;
    line  = 1'b1;
    #1;
    check("midrst_data", {24'd0, act_data}, 0);
    check("midrst_busy", {31'd0, act_busy}, 0);
    check("midrst_valid", {31'd0, act_valid}, 0);
    model_last = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b1, 30);
    check("post_rst_data", {24'd0, act_data}, 0);
    send_good(8'h12);
    wait_drain(200);
    hold(1'b1, 20);

    // Full byte sweeps on the short and odd bit periods.
    for (int s = 1; s <= 2; s++) begin
      sel        = s;
      model_last = 8'h00;
      hold(1'b1, 10);
      for (int b = 0; b < 256; b++) send_good(8'(b));
      wait_drain(100);
      hold(1'b1, 3 * cpb_of(s));
    end

    check("sb_final", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_datapath.md
Name: uart_rx_datapath

Overview:
UART receive path, the host-to-board counterpart of the demod-to-UART transmit datapath. It synchronises the serial RX line, detects and qualifies start bits, and samples 8N1 frames at mid-bit. Each good byte is presented as a single-cycle valid strobe for downstream command decoding, for example channel transmit enables. Framing errors are flagged and the block recovers cleanly from line breaks.

Parameters:
CLKS_PER_BIT, 868, system clocks per UART bit (100 MHz / 115200); legal range 4..65535.
CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
clk  input  1  top-level system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
uart_rx_in  input  1  raw serial line, idle high, asynchronous to clk.
rx_data  output  8  last correctly received byte, LSB first on the wire.
rx_valid  output  1  one-cycle strobe; rx_data is new and stable this cycle.
rx_frame_err  output  1  one-cycle strobe; stop bit sampled low.
rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0.
  - Both synchroniser flops preset to 1 (line idle).
  - FSM=IDLE, counter=0, bit index=0, shift register=0.
- Synchroniser: 2 flops on uart_rx_in. Only the second-stage output (rx_s) is used. Fixed 2-cycle input latency.
- HALF = CLKS_PER_BIT/2 (integer division).
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_busy=0.
  - rx_s=0 -> START, counter cleared.
- START:
  - Counter increments each cycle.
  - When counter==HALF-1, rx_s is sampled.
  - Sample 0 -> DATA, counter=0, bit index=0.
  - Sample 1 -> glitch; return to IDLE with no strobes.
- DATA:
  - When counter==CLKS_PER_BIT-1, rx_s is sampled and shifted in at MSB (right shift), and counter clears.
  - After the 8th sample (bit index 7) -> STOP.
  - Net result: sample points fall at HALF + k*CLKS_PER_BIT clocks after START entry, k=1..9.
- STOP (sampled at the same CLKS_PER_BIT-1 point):
  - Stop sample 1: rx_data <= shift register, rx_valid=1 for exactly the next cycle, FSM -> IDLE that same cycle. A new start bit may begin immediately, so back-to-back frames with no idle gap are supported.
  - Stop sample 0: rx_frame_err=1 for one cycle, rx_data unchanged, FSM -> BREAK.
- BREAK: wait until rx_s=1, then -> IDLE. No further strobes while the line is held low.
- rx_valid and rx_frame_err are never asserted together. Each fires at most once per frame.
- rx_busy is 1 in START, DATA, STOP and BREAK.
- Latency: rx_valid rises 2 + 1 + HALF + 9*CLKS_PER_BIT clocks (±1) after the uart_rx_in falling edge.
- Reset mid-frame: all state is aborted immediately, with no strobes. After release, if the line is mid-frame low, that low is treated as a new start bit. The bench must tolerate a resulting frame_err or garbage byte.
- Counter never exceeds CLKS_PER_BIT-1 and wraps to 0 at each sample point.

Test Plan:
- CLKS_PER_BIT=16; send 8'hA5 as 8N1 with ideal timing -> exactly one rx_valid pulse, rx_data=8'hA5, rx_frame_err never asserts, rx_busy falls the same cycle rx_valid rises.
- 4-clock low glitch on idle line (CLKS_PER_BIT=16) -> FSM returns to IDLE; no rx_valid, no rx_frame_err; rx_data stays 8'h00.
- Send 8'h3C with the stop bit forced low, then hold the line low 40 clocks, then release; send 8'h81 -> one rx_frame_err pulse, rx_data stays at its prior value, then rx_valid with 8'h81.
- Back-to-back 8'h00, 8'hFF, 8'h55 with zero idle between frames -> three rx_valid pulses spaced 10*CLKS_PER_BIT ±1 apart, with data 00, FF, 55 in order.
- Assert rst_n=0 during DATA bit 4 of 8'hC3, release while the line is idle, then send 8'h12 -> no strobe for 8'hC3; all outputs reset immediately; next rx_valid carries 8'h12.
- CLKS_PER_BIT=4 and CLKS_PER_BIT=17 (odd); 256-byte sweep 00..FF -> every byte received correctly, with no frame errors.
